// File: rtl/ps2_host_ctrl_if.sv
// Register-side bundle of the PS/2 host controller: RX byte stream out of the
// FIFO, TX command request/completion, and the error pulse vector.
interface ps2_host_ctrl_if #(
   parameter int LEVEL_W = 5
);
   logic [7:0]         rx_data;
   logic               rx_valid;
   logic               rx_ready;
   logic [LEVEL_W-1:0] rx_level;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;
   logic               tx_done;
   logic [3:0]         err_status;

   modport master (
      input  rx_data, rx_valid, rx_level, tx_ready, tx_done, err_status,
      output rx_ready, tx_data, tx_valid
   );

   modport slave (
      output rx_data, rx_valid, rx_level, tx_ready, tx_done, err_status,
      input  rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/ps2_host_ctrl.sv
// Bidirectional PS/2 host: filtered pad sampling, device-to-host receive into a
// FIFO, host-to-device command transmit with inhibit/request-to-send/ACK.
module ps2_host_ctrl #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int RX_FIFO_DEPTH  = 16,
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ps2_clk_i,
   input  logic              ps2_data_i,
   output logic              ps2_clk_oe,
   output logic              ps2_data_oe,
   ps2_host_ctrl_if.slave    bus
);
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] FIFO_FULL = LW'(RX_FIFO_DEPTH);

   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_INHIBIT, TX_SEND, TX_ACK} tx_state_t;

   rx_state_t rx_state;
   tx_state_t tx_state;

   // Pad synchronizers; idle PS/2 lines are high, so reset to 1.
   logic [SYNC_STAGES-1:0] clk_sync, data_sync;
   logic                   clk_s, data_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];

   // A level change on ps2_clk is accepted only after FILTER_LEN equal samples.
   logic          clk_filt, clk_filt_q;
   logic [FW-1:0] filt_cnt;
   logic          bit_event;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_filt   <= 1'b1;
         clk_filt_q <= 1'b1;
         filt_cnt   <= '0;
      end else begin
         clk_filt_q <= clk_filt;
         if (clk_s == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FILT_LAST) begin
            clk_filt <= clk_s;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign bit_event = clk_filt_q & ~clk_filt;

   // Shared inter-edge watchdog: only one FSM can be in a timed state at a time.
   logic          timed, tmo_hit;
   logic [TW-1:0] tmo_cnt;

   assign timed   = (rx_state == RX_SHIFT) || (tx_state == TX_SEND) || (tx_state == TX_ACK);
   assign tmo_hit = timed && !bit_event && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
      end else if (!timed || bit_event) begin
         tmo_cnt <= '0;
      end else if (!tmo_hit) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   // Receive path
   logic       tx_ready_q, tx_accept;
   logic       rx_start, rx_stop, rx_push, frame_ok;
   logic [3:0] rx_cnt;
   logic [8:0] rx_shift;
   logic [9:0] rx_frame;
   logic       rx_frame_err_q, rx_timeout_q;

   assign tx_accept = bus.tx_valid && tx_ready_q;
   assign rx_start  = (rx_state == RX_IDLE) && (tx_state == TX_IDLE) && !tx_accept &&
                      bit_event && !data_s;
   assign rx_stop   = (rx_state == RX_SHIFT) && bit_event && (rx_cnt == 4'd9);
   assign rx_frame  = {data_s, rx_shift};
   assign frame_ok  = rx_frame[9] && (^rx_frame[8:0]);
   assign rx_push   = rx_stop && frame_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_state       <= RX_IDLE;
         rx_cnt         <= '0;
         rx_shift       <= '0;
         rx_frame_err_q <= 1'b0;
         rx_timeout_q   <= 1'b0;
      end else begin
         rx_frame_err_q <= 1'b0;
         rx_timeout_q   <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_start) begin
                  rx_state <= RX_SHIFT;
                  rx_cnt   <= '0;
               end
            end
            RX_SHIFT: begin
               if (tmo_hit) begin
                  rx_state     <= RX_IDLE;
                  rx_timeout_q <= 1'b1;
               end else if (bit_event) begin
                  rx_shift <= {data_s, rx_shift[8:1]};
                  rx_cnt   <= rx_cnt + 1'b1;
                  if (rx_cnt == 4'd9) begin
                     rx_state       <= RX_IDLE;
                     rx_frame_err_q <= !frame_ok;
                  end
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // RX FIFO; a pop in the same cycle frees the slot for a push at full.
   logic [7:0]    mem [RX_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count;
   logic          pop, wr_en, rx_overflow_q;

   assign pop   = bus.rx_ready && (count != '0);
   assign wr_en = rx_push && ((count != FIFO_FULL) || pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         rx_overflow_q <= 1'b0;
      end else begin
         rx_overflow_q <= rx_push && !wr_en;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; occupancy is tracked by count, and the head is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= rx_frame[7:0];
   end

   // Transmit path: frame bits d0..d7, odd parity, stop, shifted out LSB first.
   logic [9:0]    tx_shift;
   logic [3:0]    tx_cnt;
   logic [IW-1:0] inh_cnt;
   logic          tx_done_q, tx_timeout_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_state     <= TX_IDLE;
         ps2_clk_oe   <= 1'b0;
         ps2_data_oe  <= 1'b0;
         tx_ready_q   <= 1'b0;
         tx_done_q    <= 1'b0;
         tx_timeout_q <= 1'b0;
         tx_shift     <= '0;
         tx_cnt       <= '0;
         inh_cnt      <= '0;
      end else begin
         tx_done_q    <= 1'b0;
         tx_timeout_q <= 1'b0;
         // Deasserted the cycle after an accept or RX start, so no double accept.
         tx_ready_q   <= (tx_state == TX_IDLE) && !tx_accept &&
                         (rx_state == RX_IDLE) && !rx_start;
         case (tx_state)
            TX_IDLE: begin
               if (tx_accept) begin
                  tx_shift   <= {1'b1, ~^bus.tx_data, bus.tx_data};
                  inh_cnt    <= INH_LAST;
                  ps2_clk_oe <= 1'b1;
                  tx_state   <= TX_INHIBIT;
               end
            end
            TX_INHIBIT: begin
               if (inh_cnt == '0) begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b1;
                  tx_cnt      <= '0;
                  tx_state    <= TX_SEND;
               end else begin
                  inh_cnt <= inh_cnt - 1'b1;
               end
            end
            TX_SEND: begin
               if (tmo_hit) begin
                  ps2_data_oe  <= 1'b0;
                  tx_timeout_q <= 1'b1;
                  tx_state     <= TX_IDLE;
               end else if (bit_event) begin
                  ps2_data_oe <= ~tx_shift[0];
                  tx_shift    <= tx_shift >> 1;
                  tx_cnt      <= tx_cnt + 1'b1;
                  if (tx_cnt == 4'd9) tx_state <= TX_ACK;
               end
            end
            TX_ACK: begin
               if (tmo_hit) begin
                  ps2_data_oe  <= 1'b0;
                  tx_timeout_q <= 1'b1;
                  tx_state     <= TX_IDLE;
               end else if (bit_event) begin
                  ps2_data_oe  <= 1'b0;
                  tx_done_q    <= !data_s;
                  tx_timeout_q <= data_s;
                  tx_state     <= TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   assign bus.rx_data    = (count != '0) ? mem[rd_ptr] : 8'h00;
   assign bus.rx_valid   = (count != '0);
   assign bus.rx_level   = count;
   assign bus.tx_ready   = tx_ready_q;
   assign bus.tx_done    = tx_done_q;
   assign bus.err_status = {tx_timeout_q, rx_timeout_q, rx_overflow_q, rx_frame_err_q};
endmodule
